mips_mem_arbiter: RTL

//   Shares the single off-chip memory port between the I-cache and D-cache miss/write-back engines.

---
 rtl/mips_mem_arbiter_pkg.sv | 20 ++
 rtl/mips_arb_pick.sv | 39 +++
 rtl/mips_mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared encodings for the I/D-cache memory-port arbiter.
package mips_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    // Encoding of the 1-bit "last tie winner" used by round-robin arbitration.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mips_arb_pick.sv
// Grant policy for the memory-port arbiter (combinational).
// MEM_ARB_RR_EN defined  : round-robin on simultaneous requests, using last_owner.
// MEM_ARB_RR_EN undefined: fixed priority, D-cache over I-cache.
module mips_arb_pick
    import mips_mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_i,
    output logic grant_d
);

`ifdef MEM_ARB_RR_EN
    // Ties go to the side that did not win the previous tie; single requests pass through.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (last_owner == LAST_I) grant_d = 1'b1;
            else                      grant_i = 1'b1;
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end
`else
    // Fixed priority does not look at history.
    logic unused_last;
    assign unused_last = last_owner;

    // D-cache always wins a tie; I-cache stays pending.
    always_comb begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
    end
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing the single off-chip memory port between the I-cache and
// D-cache miss/write-back engines. One requester is granted at a time; its
// op/address/data are latched at grant and the memory response is returned
// to that requester only, as a one-cycle ready pulse.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking).
module mips_mem_arbiter
    import mips_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              i_mem_ready,
    output logic [DATA_W-1:0] i_mem_rdata,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic              d_mem_ready,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic i_req, d_req, grant_i, grant_d, last_owner;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // Remember who won the most recent tie; only contested grants update it.
    always_comb begin
        last_d = last_q;
        if (state_q == ARB_IDLE && i_req && d_req)
            last_d = grant_d ? LAST_D : LAST_I;
    end

    // Tie history register, starts as if I had won last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= LAST_I;
        else        last_q <= last_d;
    end

    assign last_owner = last_q;
`else
    assign last_owner = LAST_I;
`endif

    mips_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // Next-state: grant in IDLE, wait for memory in BUSY, single response cycle in RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    wr_d    = d_mem_write;   // read+write together is treated as write
                    addr_d  = d_mem_addr;
                    wdata_d = d_mem_wdata;
                    state_d = ARB_BUSY;
                end else if (grant_i) begin
                    owner_d = OWN_I;
                    wr_d    = 1'b0;
                    addr_d  = i_mem_addr;
                    wdata_d = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                owner_d = OWN_NONE;
                state_d = ARB_IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Control state; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Transaction latches; outputs are gated by state so these need no reset.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    assign mem_read    = (state_q == ARB_BUSY) && !wr_q;
    assign mem_write   = (state_q == ARB_BUSY) &&  wr_q;
    assign mem_addr    = (state_q == ARB_BUSY) ? addr_q : '0;
    assign mem_wdata   = mem_write ? wdata_q : '0;
    assign i_mem_ready = (state_q == ARB_RESP) && (owner_q == OWN_I);
    assign d_mem_ready = (state_q == ARB_RESP) && (owner_q == OWN_D);
    assign i_mem_rdata = i_mem_ready ? rdata_q : '0;
    assign d_mem_rdata = d_mem_ready ? rdata_q : '0;

`ifndef SYNTHESIS
    // Flag a D-cache engine asserting read and write together.
    always @(posedge clk) begin
        if (rst_n && state_q == ARB_IDLE && d_mem_read && d_mem_write)
            $error("mips_mem_arbiter: d_mem_read and d_mem_write both set, treated as write");
    end
`endif

endmodule
